divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 114 +++++++++++
 tb/tb_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH clocks per operation.
// Optional DIVIDER_DIV0_FLAG_EN adds a registered div_by_zero result flag.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CALC  | one restoring step per edge, WIDTH edges total
// DONE  | result valid (ready=1) until start is released
module divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready
`ifdef DIVIDER_DIV0_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] rem_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_work;
   logic             last_step;

   // The partial remainder stays below the divisor, so a borrow out of the
   // WIDTH+1 bit trial subtraction shows up directly in its top bit.
   always_comb begin
      shifted   = {rem_q, work_q[WIDTH-1]};
      trial     = shifted - {1'b0, divisor_q};
      borrow    = trial[WIDTH];
      step_rem  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_work = {work_q[WIDTH-2:0], ~borrow};
      last_step = (cnt_q == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         divisor_q   <= '0;
         work_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         ready       <= 1'b0;
`ifdef DIVIDER_DIV0_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  divisor_q   <= divisor;
                  work_q      <= dividend;
                  rem_q       <= '0;
                  cnt_q       <= '0;
                  state_q     <= CALC;
`ifdef DIVIDER_DIV0_FLAG_EN
                  div_by_zero <= 1'b0;
`endif
               end
            end
            CALC: begin
               rem_q  <= step_rem;
               work_q <= step_work;
               if (last_step) begin
                  cnt_q       <= '0;
                  quotient    <= step_work;
                  remainder   <= step_rem;
                  ready       <= 1'b1;
                  state_q     <= DONE;
`ifdef DIVIDER_DIV0_FLAG_EN
                  div_by_zero <= (divisor_q == '0);
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (!start) begin
                  ready   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed and randomized bench for divider (WIDTH=8); results checked against plain integer division.
module tb_divider;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         ready;
`ifdef DIVIDER_DIV0_FLAG_EN
   logic         div_by_zero;
`endif

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q = '0;
   logic [W-1:0] exp_r = '0;

   divider #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .ready(ready)
`ifdef DIVIDER_DIV0_FLAG_EN
      ,
      .div_by_zero(div_by_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic void model(input int a, input int b, output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == 0) begin
         q = '1;
         r = W'(a);
      end else begin
         q = W'(a / b);
         r = W'(a % b);
      end
   endfunction

   // Caller must be away from a rising edge; the next rising edge is the accept edge.
   task automatic run_op(input int a, input int b, input bit scramble, input int hold);
      logic [W-1:0] nq, nr;
      model(a, b, nq, nr);
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      @(posedge clk);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         if (scramble) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
            start    = 1'($urandom);
         end
         @(posedge clk);
         #1;
         if (k < W) begin
            check($sformatf("calc_ready_e%0d", k), W'(ready), W'(0));
            check($sformatf("calc_q_stable_e%0d", k), quotient, exp_q);
            check($sformatf("calc_r_stable_e%0d", k), remainder, exp_r);
`ifdef DIVIDER_DIV0_FLAG_EN
            if (k == 1) check("dz_cleared_on_accept", W'(div_by_zero), W'(0));
`endif
         end else begin
            check($sformatf("ready_%0d_%0d", a, b), W'(ready), W'(1));
            check($sformatf("quot_%0d_%0d", a, b), quotient, nq);
            check($sformatf("rem_%0d_%0d", a, b), remainder, nr);
`ifdef DIVIDER_DIV0_FLAG_EN
            check($sformatf("dz_%0d_%0d", a, b), W'(div_by_zero), W'(b == 0));
`endif
         end
      end
      exp_q = nq;
      exp_r = nr;
      start = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("done_hold_ready", W'(ready), W'(1));
         check("done_hold_q", quotient, exp_q);
         check("done_hold_r", remainder, exp_r);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      check("release_ready", W'(ready), W'(0));
      check("release_q", quotient, exp_q);
      check("release_r", remainder, exp_r);
`ifdef DIVIDER_DIV0_FLAG_EN
      check("release_dz", W'(div_by_zero), W'(b == 0));
`endif
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", W'(ready), W'(0));
      check("reset_q", quotient, W'(0));
      check("reset_r", remainder, W'(0));
`ifdef DIVIDER_DIV0_FLAG_EN
      check("reset_dz", W'(div_by_zero), W'(0));
`endif
      reset = 1'b0;

      run_op(100, 7, 1'b0, 2);
      run_op(5, 9, 1'b0, 0);
      run_op(255, 1, 1'b0, 4);
      run_op(37, 0, 1'b0, 1);
      run_op(37, 5, 1'b0, 1);

      // idle with start low keeps the previous result
      repeat (2) @(posedge clk);
      #1;
      check("idle_q_hold", quotient, exp_q);
      check("idle_r_hold", remainder, exp_r);

      // abort 200/3 on the fourth CALC edge
      start    = 1'b1;
      dividend = W'(200);
      divisor  = W'(3);
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ready", W'(ready), W'(0));
      check("abort_q", quotient, W'(0));
      check("abort_r", remainder, W'(0));
      exp_q = '0;
      exp_r = '0;
      reset = 1'b0;
      run_op(200, 3, 1'b0, 1);

      for (int i = 0; i < 5; i++) begin
         run_op(int'($urandom_range(255, 0)), int'($urandom_range(255, 1)), 1'b1, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
